// File: rtl/arm_seq_pkg.sv
// rtl/arm_seq_pkg.sv - class codes, state encoding and opcode bit positions for the instruction sequencer
package arm_seq_pkg;

  localparam logic [3:0] CLS_INVALID = 4'd0;
  localparam logic [3:0] CLS_MUL     = 4'd1;
  localparam logic [3:0] CLS_MULL    = 4'd2;
  localparam logic [3:0] CLS_SWP     = 4'd3;
  localparam logic [3:0] CLS_HW_REG  = 4'd4;
  localparam logic [3:0] CLS_HW_IMM  = 4'd5;
  localparam logic [3:0] CLS_SDT     = 4'd6;
  localparam logic [3:0] CLS_DP_REG  = 4'd7;
  localparam logic [3:0] CLS_LDST    = 4'd8;
  localparam logic [3:0] CLS_BLK     = 4'd9;
  localparam logic [3:0] CLS_BR      = 4'd10;
  localparam logic [3:0] CLS_DP_IMM  = 4'd11;

  localparam int BIT_L    = 20;
  localparam int BIT_W    = 21;
  localparam int BIT_B    = 22;
  localparam int BIT_P    = 24;
  localparam int BIT_LINK = 24;

  typedef enum logic [3:0] {
    IDLE, DECODE, EXEC, ADDR, MEM, SWP_RD, SWP_WR, BLOCK, WB, BRANCH, FLUSH
  } seq_state_t;

  // Classes 0 and 12-15 all trap as undefined.
  function automatic logic is_invalid(input logic [3:0] cls);
    return (cls == CLS_INVALID) || (cls >= 4'd12);
  endfunction

endpackage

// File: rtl/blk_reg_picker.sv
// rtl/blk_reg_picker.sv - lowest-set-bit priority encoder over a 16-bit register list
module blk_reg_picker (
  input  logic [15:0] list,
  output logic [3:0]  idx,
  output logic        empty
);

  always_comb begin
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list[i]) idx = i[3:0];
    end
    empty = (list == 16'd0);
  end

endmodule

// File: rtl/arm_instr_sequencer.sv
// rtl/arm_instr_sequencer.sv - multi-cycle fetch-to-datapath control FSM; SEQ_PERF_CNT_EN adds perf counters
module arm_instr_sequencer
  import arm_seq_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int MULL_EXTRA = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] opcode,
  input  logic [3:0]  dec_class,
  input  logic        cond_pass,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_byte,
  input  logic        mem_ready,
  output logic [3:0]  blk_reg_idx,
  output logic        alu_en,
  output logic        reg_we,
  output logic        base_we,
  output logic        pc_we,
  output logic        link_we,
  output logic        retire,
  output logic        undef,
  output logic        busy
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [7:0] MUL_LOAD  = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] MULL_LOAD = 8'(MUL_CYCLES + MULL_EXTRA - 1);

  seq_state_t  state_q, state_d;
  logic [31:0] op_q;
  logic [3:0]  cls_q;
  logic [7:0]  cnt_q;
  logic [15:0] rem_q;
  logic [3:0]  blk_idx;
  logic        blk_empty;
  logic        last_beat;
  logic        unused_op_bits;

  assign unused_op_bits = ^{op_q[31:25], op_q[19:16]};

  blk_reg_picker u_picker (
    .list  (rem_q),
    .idx   (blk_idx),
    .empty (blk_empty)
  );

  assign last_beat = ((rem_q & (rem_q - 16'd1)) == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= 32'd0;
      cls_q <= 4'd0;
      cnt_q <= 8'd0;
      rem_q <= 16'd0;
    end else begin
      if (state_q == IDLE && instr_valid) begin
        op_q  <= opcode;
        cls_q <= dec_class;
      end
      if (state_q == DECODE) begin
        cnt_q <= (cls_q == CLS_MUL) ? MUL_LOAD : (cls_q == CLS_MULL) ? MULL_LOAD : 8'd0;
        rem_q <= op_q[15:0];
      end else if (state_q == EXEC && cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end else if (state_q == BLOCK && mem_ready) begin
        rem_q <= rem_q & ~(16'd1 << blk_idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (instr_valid) state_d = DECODE;
      DECODE: begin
        if (!cond_pass) state_d = IDLE;
        else begin
          case (cls_q)
            CLS_DP_REG, CLS_DP_IMM, CLS_MUL, CLS_MULL:  state_d = EXEC;
            CLS_HW_REG, CLS_HW_IMM, CLS_SDT, CLS_LDST:  state_d = ADDR;
            CLS_SWP: state_d = SWP_RD;
            CLS_BLK: state_d = (op_q[15:0] == 16'd0) ? WB : BLOCK;
            CLS_BR:  state_d = BRANCH;
            default: state_d = IDLE;
          endcase
        end
      end
      EXEC:   if (cnt_q == 8'd0) state_d = WB;
      ADDR:   state_d = MEM;
      MEM:    if (mem_ready) state_d = WB;
      SWP_RD: if (mem_ready) state_d = SWP_WR;
      SWP_WR: if (mem_ready) state_d = WB;
      BLOCK:  if (blk_empty || (mem_ready && last_beat)) state_d = WB;
      WB:     state_d = IDLE;
      BRANCH: state_d = FLUSH;
      FLUSH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_byte    = 1'b0;
    blk_reg_idx = 4'd0;
    alu_en      = 1'b0;
    reg_we      = 1'b0;
    base_we     = 1'b0;
    pc_we       = 1'b0;
    link_we     = 1'b0;
    retire      = 1'b0;
    undef       = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE:   instr_ready = !rst;
      DECODE: begin
        retire = !cond_pass || is_invalid(cls_q);
        undef  = cond_pass && is_invalid(cls_q);
      end
      EXEC, ADDR: alu_en = 1'b1;
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = !op_q[BIT_L];
        mem_byte = op_q[BIT_B] && (cls_q == CLS_LDST);
      end
      SWP_RD: begin
        mem_req  = 1'b1;
        mem_byte = op_q[BIT_B];
      end
      SWP_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_byte = op_q[BIT_B];
      end
      BLOCK: begin
        mem_req     = !blk_empty;
        mem_we      = !blk_empty && !op_q[BIT_L];
        blk_reg_idx = blk_idx;
      end
      WB: begin
        retire = 1'b1;
        case (cls_q)
          CLS_DP_REG, CLS_DP_IMM:     reg_we = (op_q[24:23] != 2'b10);
          CLS_MUL, CLS_MULL, CLS_SWP: reg_we = 1'b1;
          CLS_HW_REG, CLS_HW_IMM, CLS_SDT, CLS_LDST, CLS_BLK: begin
            reg_we  = op_q[BIT_L];
            base_we = op_q[BIT_W] || !op_q[BIT_P];
          end
          default: ;
        endcase
      end
      BRANCH: begin
        pc_we   = 1'b1;
        link_we = op_q[BIT_LINK];
      end
      FLUSH:  retire = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (retire)                perf_retired <= perf_retired + 32'd1;
      if (mem_req && !mem_ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_arm_instr_sequencer.sv
// tb/tb_arm_instr_sequencer.sv - self-checking bench for arm_instr_sequencer
module tb_arm_instr_sequencer;

  localparam int MUL_CYCLES = 2;
  localparam int MULL_EXTRA = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] opcode = 32'd0;
  logic [3:0]  dec_class = 4'd0;
  logic        cond_pass = 1'b0;
  logic        mem_req, mem_we, mem_byte;
  logic        mem_ready = 1'b0;
  logic [3:0]  blk_reg_idx;
  logic        alu_en, reg_we, base_we, pc_we, link_we, retire, undef, busy;

  always #5 clk = ~clk;

  arm_instr_sequencer #(.MUL_CYCLES(MUL_CYCLES), .MULL_EXTRA(MULL_EXTRA)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .dec_class(dec_class), .cond_pass(cond_pass),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_ready(mem_ready),
    .blk_reg_idx(blk_reg_idx), .alu_en(alu_en), .reg_we(reg_we), .base_we(base_we),
    .pc_we(pc_we), .link_we(link_we), .retire(retire), .undef(undef), .busy(busy)
  );

  int n_asserts = 0;
  int n_fails   = 0;
  int waits[$];

  int e_lat, e_alu, e_alu_first, e_memreq, e_memwe, e_byte, e_reg, e_base, e_pc, e_link, e_undef, e_pc_cyc;
  int e_idx[$];
  int o_lat, o_alu, o_alu_first, o_memreq, o_memwe, o_byte, o_reg, o_base, o_pc, o_link, o_undef, o_pc_cyc, o_busy;
  int o_idx[$];

  task automatic check(input string tag, input string what, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, what, obs, exp);
    end
  endtask

  task automatic random_waits();
    waits.delete();
    for (int i = 0; i < 20; i++) waits.push_back($urandom_range(0, 3));
  endtask

  // Expected behaviour derived from the class rules: beats, wait cycles and strobe counts.
  task automatic model(input logic [31:0] op, input logic [3:0] cls, input logic cond);
    int mc;
    e_lat = 0; e_alu = 0; e_alu_first = -1; e_memreq = 0; e_memwe = 0; e_byte = 0;
    e_reg = 0; e_base = 0; e_pc = 0; e_link = 0; e_undef = 0; e_pc_cyc = -1;
    e_idx.delete();
    if (!cond) begin
      e_lat = 1;
    end else if (cls == 0 || cls >= 12) begin
      e_lat = 1; e_undef = 1;
    end else if (cls == 7 || cls == 11) begin
      e_alu = 1; e_alu_first = 2; e_lat = 3; e_reg = (op[24:23] != 2'b10);
    end else if (cls == 1 || cls == 2) begin
      mc = MUL_CYCLES + ((cls == 2) ? MULL_EXTRA : 0);
      e_alu = mc; e_alu_first = 2; e_lat = 2 + mc; e_reg = 1;
    end else if (cls == 10) begin
      e_lat = 3; e_pc = 1; e_link = op[24]; e_pc_cyc = 2;
    end else if (cls == 3) begin
      e_memreq = waits[0] + waits[1] + 2; e_memwe = waits[1] + 1;
      e_byte = op[22] ? e_memreq : 0; e_lat = 2 + e_memreq; e_reg = 1;
    end else if (cls == 9) begin
      for (int i = 0; i < 16; i++) if (op[i]) e_idx.push_back(i);
      foreach (e_idx[k]) e_memreq += waits[k] + 1;
      e_memwe = op[20] ? 0 : e_memreq; e_lat = 2 + e_memreq;
      e_reg = op[20]; e_base = op[21] || !op[24];
    end else begin
      e_alu = 1; e_alu_first = 2; e_memreq = waits[0] + 1;
      e_memwe = op[20] ? 0 : e_memreq; e_byte = (cls == 8 && op[22]) ? e_memreq : 0;
      e_lat = 3 + e_memreq; e_reg = op[20]; e_base = op[21] || !op[24];
    end
  endtask

  task automatic run_instr(input string tag, input logic [31:0] op, input logic [3:0] cls, input logic cond);
    int beat, bc;
    bit done;
    model(op, cls, cond);
    o_lat = -1; o_alu = 0; o_alu_first = -1; o_memreq = 0; o_memwe = 0; o_byte = 0;
    o_reg = 0; o_base = 0; o_pc = 0; o_link = 0; o_undef = 0; o_pc_cyc = -1; o_busy = 0;
    o_idx.delete();
    beat = 0; bc = 0; done = 0;
    @(negedge clk);
    check(tag, "ready_before", int'(instr_ready), 1);
    instr_valid = 1'b1; opcode = op; dec_class = cls; cond_pass = cond; mem_ready = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 300 && !done; c++) begin
      @(negedge clk);
      instr_valid = 1'b0; opcode = $urandom; dec_class = 4'($urandom);
      if (alu_en) begin o_alu++; if (o_alu_first < 0) o_alu_first = c; end
      if (mem_req) o_memreq++;
      if (mem_req && mem_we) o_memwe++;
      if (mem_byte) o_byte++;
      if (reg_we) o_reg++;
      if (base_we) o_base++;
      if (pc_we) begin o_pc++; o_pc_cyc = c; end
      if (link_we) o_link++;
      if (undef) o_undef++;
      if (busy) o_busy++;
      if (retire) begin o_lat = c; done = 1; end
      if (mem_req) begin
        if (bc == waits[beat]) begin
          mem_ready = 1'b1;
          if (cls == 9) o_idx.push_back(int'(blk_reg_idx));
          beat++; bc = 0;
        end else begin
          mem_ready = 1'b0; bc++;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
    check(tag, "retired", int'(done), 1);
    check(tag, "latency", o_lat, e_lat);
    check(tag, "busy_cycles", o_busy, e_lat);
    check(tag, "alu_cycles", o_alu, e_alu);
    check(tag, "alu_first", o_alu_first, e_alu_first);
    check(tag, "memreq_cycles", o_memreq, e_memreq);
    check(tag, "memwe_cycles", o_memwe, e_memwe);
    check(tag, "byte_cycles", o_byte, e_byte);
    check(tag, "reg_we", o_reg, e_reg);
    check(tag, "base_we", o_base, e_base);
    check(tag, "pc_we", o_pc, e_pc);
    check(tag, "pc_cycle", o_pc_cyc, e_pc_cyc);
    check(tag, "link_we", o_link, e_link);
    check(tag, "undef", o_undef, e_undef);
    check(tag, "beats", o_idx.size(), e_idx.size());
    foreach (e_idx[k]) if (k < o_idx.size()) check(tag, "blk_idx", o_idx[k], e_idx[k]);
    mem_ready = 1'b0;
    @(negedge clk);
    check(tag, "retire_pulse", int'(retire), 0);
    check(tag, "ready_after", int'(instr_ready), 1);
  endtask

  initial begin
    logic [31:0] op;
    logic [3:0]  cls;
    logic        cnd;
    int          k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", "instr_ready", int'(instr_ready), 0);
    check("reset", "busy", int'(busy), 0);
    check("reset", "mem_req", int'(mem_req), 0);
    check("reset", "retire", int'(retire), 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset", "ready_rise", int'(instr_ready), 1);

    random_waits();
    run_instr("add", 32'h0000_0000, 4'd7, 1'b1);
    run_instr("cmp", 32'h0100_0000, 4'd11, 1'b1);
    random_waits(); waits[0] = 3;
    run_instr("ldr", 32'h0130_0000, 4'd8, 1'b1);
    random_waits();
    run_instr("strb_post", 32'h0040_0000, 4'd8, 1'b1);
    random_waits(); waits[0] = 1; waits[1] = 2; waits[2] = 0;
    run_instr("ldm", 32'h0110_8005, 4'd9, 1'b1);
    run_instr("ldm_empty", 32'h0110_0000, 4'd9, 1'b1);
    run_instr("bl", 32'h0100_0000, 4'd10, 1'b1);
    run_instr("bl_nocond", 32'h0100_0000, 4'd10, 1'b0);
    run_instr("undef", 32'h0000_0000, 4'd0, 1'b1);
    run_instr("undef15", 32'hFFFF_FFFF, 4'd15, 1'b1);
    run_instr("mul", 32'h0000_0000, 4'd1, 1'b1);
    run_instr("mull", 32'h0000_0000, 4'd2, 1'b1);
    random_waits();
    run_instr("swpb", 32'h0040_0000, 4'd3, 1'b1);

    for (int n = 0; n < 60; n++) begin
      random_waits();
      op  = $urandom;
      cls = 4'($urandom);
      cnd = ($urandom_range(0, 7) != 0);
      run_instr("rand", op, cls, cnd);
    end

    @(negedge clk);
    instr_valid = 1'b1; opcode = 32'd0; dec_class = 4'd3; cond_pass = 1'b1; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    for (k = 0; k < 20 && !(mem_req && mem_we); k++) begin
      mem_ready = mem_req;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    check("swp_rst", "reached_write", int'(k < 20), 1);
    rst = 1'b1;
    @(negedge clk);
    check("swp_rst", "mem_req", int'(mem_req), 0);
    check("swp_rst", "busy", int'(busy), 0);
    check("swp_rst", "retire", int'(retire), 0);
    check("swp_rst", "instr_ready", int'(instr_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("swp_rst", "ready_rise", int'(instr_ready), 1);
    check("swp_rst", "retire_after", int'(retire), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
